// File: rtl/a429_rx_poller.sv
// Wishbone master that polls A429 RX channels round-robin and queues {chan, word}
// into a first-word-fall-through FIFO for the CPU.
module a429_rx_poller #(
  parameter int unsigned CHAN_NUM = 8,
  parameter int unsigned CHAN_AW  = 3,
  parameter int unsigned REGS_AW  = 2,
  parameter int unsigned STAT_OFS = 1,
  parameter int unsigned DATA_OFS = 2,
  parameter int unsigned RDY_BIT  = 0,
  parameter int unsigned FIFO_AW  = 4,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       clr_i,
  input  logic [CHAN_NUM-1:0]        irq_i,
  output logic                       m_cyc_o,
  output logic                       m_stb_o,
  output logic [CHAN_AW+REGS_AW-1:0] m_adr_o,
  output logic                       m_wnr_o,
  input  logic [31:0]                m_dat_i,
  input  logic                       m_ack_i,
  input  logic                       q_rd_i,
  output logic [31:0]                q_dat_o,
  output logic [CHAN_AW-1:0]         q_chan_o,
  output logic                       q_empty_o,
  output logic [FIFO_AW:0]           q_cnt_o,
  output logic                       err_o
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned AW    = CHAN_AW + REGS_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned EW    = CHAN_AW + 32;
  localparam int unsigned TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StStat, StData, StPush} state_e;

  state_e               state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic [AW-1:0]        adr_q, adr_d;
  logic [CHAN_AW-1:0]   chan_q, chan_d;
  logic [CHAN_AW-1:0]   last_q, last_d;
  logic [31:0]          word_q, word_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [EW-1:0]        mem_q [Depth];
  logic [EW-1:0]        head;
  logic [CHAN_AW-1:0]   pick;
  logic                 push, pop, err_set, tmo_hit;

  // First requesting channel strictly after the last served one, wrapping.
  function automatic logic [CHAN_AW-1:0] rr_pick(input logic [CHAN_NUM-1:0] req,
                                                 input logic [CHAN_AW-1:0]  last);
    logic [CHAN_AW-1:0] sel;
    int                 idx;
    sel = last;
    for (int i = int'(CHAN_NUM); i >= 1; i--) begin
      idx = (int'(last) + i) % int'(CHAN_NUM);
      if (req[idx]) sel = CHAN_AW'(idx);
    end
    return sel;
  endfunction

  assign pick    = rr_pick(irq_i, last_q);
  assign tmo_hit = cyc_q && !m_ack_i && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    chan_d  = chan_q;
    last_d  = last_q;
    word_d  = word_q;
    tmo_d   = cyc_q ? tmo_q + TW'(1) : tmo_q;
    err_set = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_i && (|irq_i) && (cnt_q <= CW'(Depth - 1))) begin
          chan_d  = pick;
          adr_d   = {pick, REGS_AW'(STAT_OFS)};
          cyc_d   = 1'b1;
          tmo_d   = '0;
          state_d = StStat;
        end
      end
      StStat: begin
        if (cyc_q && m_ack_i) begin
          cyc_d  = 1'b0;
          last_d = chan_q;
          if (m_dat_i[RDY_BIT]) begin
            adr_d   = {chan_q, REGS_AW'(DATA_OFS)};
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end else if (tmo_hit) begin
          cyc_d   = 1'b0;
          err_set = 1'b1;
          last_d  = chan_q;
          state_d = StIdle;
        end
      end
      StData: begin
        // Entered with the bus idle for one cycle; the data access starts here.
        if (!cyc_q) begin
          cyc_d = 1'b1;
          tmo_d = '0;
        end else if (m_ack_i) begin
          word_d  = m_dat_i;
          cyc_d   = 1'b0;
          state_d = StPush;
        end else if (tmo_hit) begin
          cyc_d   = 1'b0;
          err_set = 1'b1;
          last_d  = chan_q;
          state_d = StIdle;
        end
      end
      StPush: begin
        push    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    err_d = err_set | (err_q & ~clr_i);
  end

  always_comb begin
    pop      = q_rd_i && (cnt_q != '0);
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cyc_q    <= 1'b0;
      adr_q    <= '0;
      chan_q   <= '0;
      last_q   <= CHAN_AW'(CHAN_NUM - 1);
      word_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      chan_q   <= chan_d;
      last_q   <= last_d;
      word_q   <= word_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {chan_q, word_q};
  end

  assign head      = mem_q[rd_ptr_q];
  assign q_empty_o = (cnt_q == '0);
  assign q_dat_o   = q_empty_o ? 32'd0 : head[31:0];
  assign q_chan_o  = q_empty_o ? '0 : head[EW-1:32];
  assign q_cnt_o   = cnt_q;
  assign err_o     = err_q;
  assign m_cyc_o   = cyc_q;
  assign m_stb_o   = cyc_q;
  assign m_adr_o   = adr_q;
  assign m_wnr_o   = 1'b0;

endmodule

// File: tb/tb_a429_rx_poller.sv
// Bench for a429_rx_poller: Wishbone slave model with random latency/data, plus a
// round-robin service model predicting bus addresses and FIFO contents.
module tb_a429_rx_poller;

  localparam int CN = 8;

  logic        clk, rst, en, clr;
  logic [7:0]  irq;
  logic        m_cyc, m_stb, m_wnr, m_ack;
  logic [4:0]  m_adr;
  logic [31:0] m_dat;
  logic        q_rd, q_empty, err;
  logic [31:0] q_dat;
  logic [2:0]  q_chan;
  logic [2:0]  q_cnt;

  a429_rx_poller #(.FIFO_AW(2)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .irq_i(irq),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_adr_o(m_adr), .m_wnr_o(m_wnr),
    .m_dat_i(m_dat), .m_ack_i(m_ack), .q_rd_i(q_rd), .q_dat_o(q_dat),
    .q_chan_o(q_chan), .q_empty_o(q_empty), .q_cnt_o(q_cnt), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] adr; logic [31:0] dat;} acc_t;
  typedef struct packed {logic [2:0] chan; logic [31:0] word;} ent_t;

  acc_t        log_q[$];
  ent_t        exp_q[$];
  logic [7:0]  rdy;
  logic        hang, fix_en;
  logic [2:0]  hang_chan;
  logic [31:0] fix_word;
  int          checks, errors, li, mlast;

  // Slave: acks after 0..2 wait cycles, one-cycle ack pulse, logs every completed read.
  initial begin
    int   lat;
    acc_t a;
    lat   = 0;
    m_ack = 1'b0;
    m_dat = 32'd0;
    forever begin
      @(negedge clk);
      if (m_ack) begin
        m_ack = 1'b0;
      end else if (m_cyc && m_stb && !(hang && m_adr[4:2] == hang_chan)) begin
        if (lat == 0) begin
          if (m_adr[1:0] == 2'd1) m_dat = {31'd0, rdy[m_adr[4:2]]};
          else m_dat = fix_en ? fix_word : $urandom;
          m_ack = 1'b1;
          a.adr = m_adr;
          a.dat = m_dat;
          log_q.push_back(a);
          lat = $urandom_range(0, 2);
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int model_pick(input logic [7:0] mask, input int last);
    int c;
    c = last;
    repeat (CN) begin
      c = (c + 1) % CN;
      if (mask[c]) return c;
    end
    return 0;
  endfunction

  task automatic wait_log(output bit ok);
    int t;
    t = 0;
    while (log_q.size() <= li && t < 300) begin
      @(negedge clk);
      #2;
      t++;
    end
    ok = (log_q.size() > li);
  endtask

  // One service: status read of the predicted channel, then a data read if ready.
  task automatic step(input logic [7:0] mask, input bit drop_en);
    bit   ok;
    int   c;
    ent_t e;
    c = model_pick(mask, mlast);
    wait_log(ok);
    if (drop_en) en = 1'b0;
    chk("stat_seen", 64'(ok), 64'd1);
    if (!ok) return;
    chk("stat_adr", 64'(log_q[li].adr), 64'({c[2:0], 2'd1}));
    li++;
    mlast = c;
    if (rdy[c]) begin
      wait_log(ok);
      chk("data_seen", 64'(ok), 64'd1);
      if (!ok) return;
      chk("data_adr", 64'(log_q[li].adr), 64'({c[2:0], 2'd2}));
      e.chan = c[2:0];
      e.word = log_q[li].dat;
      exp_q.push_back(e);
      li++;
    end
  endtask

  task automatic pop_check();
    ent_t e;
    e = exp_q.pop_front();
    chk("q_empty_head", 64'(q_empty), 64'd0);
    chk("q_chan", 64'(q_chan), 64'(e.chan));
    chk("q_dat", 64'(q_dat), 64'(e.word));
    q_rd = 1'b1;
    @(negedge clk);
    #2;
    q_rd = 1'b0;
  endtask

  task automatic settle();
    en = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    chk("no_extra_access", 64'(log_q.size()), 64'(li));
    chk("bus_idle", 64'(m_cyc), 64'd0);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_check();
    chk("drained_empty", 64'(q_empty), 64'd1);
    chk("drained_cnt", 64'(q_cnt), 64'd0);
  endtask

  task automatic round(input logic [7:0] mask, input logic [7:0] rmask, input int k);
    irq = mask;
    rdy = rmask;
    en  = 1'b1;
    for (int i = 0; i < k; i++) begin
      step(mask, i == k - 1);
      if (!q_empty && exp_q.size() > 0) pop_check();
    end
    settle();
    drain();
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    en   = 1'b0;
    q_rd = 1'b0;
    clr  = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    #2;
    mlast = CN - 1;
    exp_q.delete();
    li = log_q.size();
  endtask

  initial begin
    int t, li0, n;
    checks = 0; errors = 0; li = 0; mlast = CN - 1;
    rst = 1'b0; en = 1'b0; clr = 1'b0; irq = 8'h00; q_rd = 1'b0;
    rdy = 8'h00; hang = 1'b0; hang_chan = 3'd0; fix_en = 1'b0; fix_word = 32'd0;
    #1;
    chk("rst_cyc", 64'(m_cyc), 64'd0);
    chk("rst_stb", 64'(m_stb), 64'd0);
    chk("rst_adr", 64'(m_adr), 64'd0);
    chk("rst_wnr", 64'(m_wnr), 64'd0);
    chk("rst_empty", 64'(q_empty), 64'd1);
    chk("rst_cnt", 64'(q_cnt), 64'd0);
    chk("rst_qdat", 64'(q_dat), 64'd0);
    chk("rst_qchan", 64'(q_chan), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    do_reset();

    // Single word from channel 2.
    fix_en = 1'b1; fix_word = 32'hA5A5_1234;
    irq = 8'h04; rdy = 8'h04; en = 1'b1;
    step(8'h04, 1'b1);
    settle();
    chk("single_cnt", 64'(q_cnt), 64'd1);
    chk("single_chan", 64'(q_chan), 64'd2);
    chk("single_word", 64'(q_dat), 64'hA5A5_1234);
    drain();
    fix_en = 1'b0;

    // Fairness between channels 0 and 7 from the reset pointer.
    do_reset();
    li0 = li;
    round(8'h81, 8'hFF, 4);
    chk("fair_0", 64'(log_q[li0].adr), 64'({3'd0, 2'd1}));
    chk("fair_1", 64'(log_q[li0 + 2].adr), 64'({3'd7, 2'd1}));
    chk("fair_2", 64'(log_q[li0 + 4].adr), 64'({3'd0, 2'd1}));
    chk("fair_3", 64'(log_q[li0 + 6].adr), 64'({3'd7, 2'd1}));

    // Channel 3 not ready: next access is the status read of channel 4.
    li0 = li;
    round(8'h18, 8'h10, 4);
    chk("nrdy_first", 64'(log_q[li0].adr), 64'({3'd3, 2'd1}));
    chk("nrdy_next", 64'(log_q[li0 + 1].adr), 64'({3'd4, 2'd1}));

    // Full FIFO stalls polling until one pop.
    irq = 8'h01; rdy = 8'hFF; en = 1'b1;
    for (int i = 0; i < 4; i++) step(8'h01, 1'b0);
    repeat (30) @(negedge clk);
    #2;
    chk("full_cnt", 64'(q_cnt), 64'd4);
    chk("full_no_cyc", 64'(m_cyc), 64'd0);
    chk("full_no_access", 64'(log_q.size()), 64'(li));
    pop_check();
    step(8'h01, 1'b1);
    repeat (10) @(negedge clk);
    #2;
    chk("full_refill_cnt", 64'(q_cnt), 64'd4);
    settle();
    drain();

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      round(8'($urandom_range(1, 255)), 8'($urandom), 6);
    end

    // Timeout on channel 1, then service continues at channel 2.
    do_reset();
    hang = 1'b1; hang_chan = 3'd1;
    irq = 8'h06; rdy = 8'h04; en = 1'b1;
    t = 0;
    while (!m_cyc && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("tmo_adr", 64'(m_adr), 64'({3'd1, 2'd1}));
    n = 0;
    while (m_cyc && n < 100) begin
      n++;
      @(negedge clk);
      #2;
    end
    chk("tmo_len", 64'(n), 64'd15);
    chk("tmo_err", 64'(err), 64'd1);
    mlast = 1;
    step(8'h06, 1'b1);
    settle();
    drain();
    chk("err_sticky", 64'(err), 64'd1);
    clr = 1'b1;
    @(negedge clk);
    #2;
    clr = 1'b0;
    chk("err_clr", 64'(err), 64'd0);
    hang = 1'b0;

    // Asynchronous reset during a data access with 3 entries queued.
    do_reset();
    irq = 8'h01; rdy = 8'hFF; en = 1'b1;
    for (int i = 0; i < 3; i++) step(8'h01, 1'b0);
    t = 0;
    while (!(q_cnt == 3'd3 && m_cyc && m_adr == 5'b000_10) && t < 200) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("rst_found_data", 64'(t < 200), 64'd1);
    rst = 1'b0;
    en  = 1'b0;
    #1;
    chk("arst_cyc", 64'(m_cyc), 64'd0);
    chk("arst_empty", 64'(q_empty), 64'd1);
    chk("arst_cnt", 64'(q_cnt), 64'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    li = log_q.size();
    exp_q.delete();
    mlast = CN - 1;
    li0 = li;
    irq = 8'h03; en = 1'b1;
    step(8'h03, 1'b1);
    settle();
    chk("arst_restart", 64'(log_q[li0].adr), 64'({3'd0, 2'd1}));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/a429_rx_poller.md
Name: a429_rx_poller

Overview:
- Wishbone master that drains received ARINC429 words from the multi-channel A429 controller without CPU involvement.
- Scans the per-channel interrupt lines round-robin and reads the selected channel's status register.
- If a word is ready, reads the data register and pushes {channel, word} into an internal FIFO.
- The CPU pops the FIFO through a simple read/pop port.
- Sits between the A429 multi-channel slave port and the CPU-side glue; it is the sole master on that port while enabled.

Parameters:
- CHAN_NUM, 8: number of polled channels (2..32).
- CHAN_AW, 3: channel index width; must be >= clog2(CHAN_NUM).
- REGS_AW, 2: per-channel register address width.
- STAT_OFS, 1: per-channel status register offset.
- DATA_OFS, 2: per-channel RX data register offset.
- RDY_BIT, 0: bit of the status word meaning "RX word available".
- FIFO_AW, 4: FIFO depth is 2**FIFO_AW entries.
- TIMEOUT, 15: maximum cycles to wait for m_ack_i before the access is aborted.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset, asynchronous, active-low.
- en_i, input, 1: polling enable.
- clr_i, input, 1: one-cycle pulse; clears err_o.
- irq_i, input, CHAN_NUM: per-channel interrupt, active high.
- m_cyc_o, output, 1: Wishbone cycle.
- m_stb_o, output, 1: Wishbone strobe.
- m_adr_o, output, CHAN_AW+REGS_AW: address = {chan, reg}.
- m_wnr_o, output, 1: write-not-read; always 0.
- m_dat_i, input, 32: read data.
- m_ack_i, input, 1: acknowledge.
- q_rd_i, input, 1: pop the head entry.
- q_dat_o, output, 32: head entry word.
- q_chan_o, output, CHAN_AW: head entry channel.
- q_empty_o, output, 1: FIFO empty.
- q_cnt_o, output, FIFO_AW+1: FIFO occupancy.
- err_o, output, 1: sticky bus timeout flag.

Behaviour:
- Reset values:
  - Outputs: m_cyc_o=0, m_stb_o=0, m_adr_o=0, m_wnr_o=0, q_empty_o=1, q_cnt_o=0, q_dat_o=0, q_chan_o=0, err_o=0.
  - Internal: FSM in IDLE, last-served pointer = CHAN_NUM-1, FIFO pointers = 0.
- FSM states: IDLE, STAT, DATA, PUSH.
- IDLE:
  - Condition to leave: en_i=1 and irq_i!=0 and q_cnt_o <= 2**FIFO_AW-1.
  - On leaving, the channel is chosen round-robin: first set irq bit strictly after the last-served pointer, wrapping modulo CHAN_NUM.
  - Then: register chan, drive m_adr_o={chan,STAT_OFS}, assert m_cyc_o and m_stb_o, go to STAT.
  - Decision latency is 1 cycle.
- STAT (on m_ack_i):
  - Deassert cyc/stb for exactly one cycle; update the last-served pointer to chan.
  - If m_dat_i[RDY_BIT]=1, go to DATA with m_adr_o={chan,DATA_OFS}; otherwise return to IDLE.
- DATA (on m_ack_i):
  - Latch m_dat_i, deassert cyc/stb, go to PUSH.
- PUSH:
  - Write {chan, word} into the FIFO; go to IDLE.
  - The FIFO cannot be full here, because entry to IDLE->STAT requires a free slot and only one entry is in flight.
- Bus rules:
  - m_cyc_o and m_stb_o are always equal and held until m_ack_i or timeout.
  - m_adr_o is stable while stb is asserted.
  - m_wnr_o is constant 0.
- Timeout:
  - A per-access counter resets at each stb assertion.
  - If it reaches TIMEOUT without ack: drop cyc/stb, set err_o, advance the last-served pointer to chan, go to IDLE.
  - No FIFO write occurs on timeout.
- err_o:
  - Cleared only by clr_i or reset.
  - If clr_i and a new timeout occur in the same cycle, err_o=1 (set wins).
- en_i deasserted:
  - Mid-access, the current access and any pending PUSH complete normally; no new scan starts.
- FIFO:
  - First-word-fall-through: q_dat_o/q_chan_o show the head whenever q_empty_o=0.
  - q_rd_i pops on the rising edge; q_rd_i while empty is ignored and occupancy stays 0.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pointers are FIFO_AW bits and wrap naturally.
  - q_cnt_o is registered and exact every cycle.
- Asynchronous reset mid-access drops cyc/stb immediately and discards FIFO contents.
- Channels with irq_i=0 are never addressed; CHAN_NUM is not padded to a power of two.

Test Plan:
- Single word: irq_i=8'h04, status RDY=1, data 32'hA5A5_1234 -> bus reads adr {2,1} then {2,2}; FIFO entry chan=2, word=A5A5_1234; q_cnt_o=1.
- Fairness: irq_i=8'h81 held, status always RDY -> service order 0,7,0,7 (pointer starts at 7); each channel gets a FIFO entry every second scan.
- Not ready: status RDY=0 on chan 3 -> no DATA access and no FIFO push; next scan starts at chan 4 or later.
- Full: FIFO_AW=2, 4 entries pushed, irq held -> no m_cyc_o until q_rd_i pops one; then exactly one more read pair; q_cnt_o returns to 4.
- Timeout: slave never acks chan 1 -> stb drops after 15 cycles, err_o=1, polling continues at chan 2; clr_i -> err_o=0.
- Reset: rst_i=0 during DATA with 3 entries queued -> m_cyc_o=0, q_empty_o=1 and q_cnt_o=0 immediately; after release polling restarts from chan 0.
